// File: rtl/br_wb_queue.sv
// rtl/br_wb_queue.sv - register-bank writeback queue with read-port forwarding
//
// Buffers register writeback requests in a small FIFO and drains one entry
// per cycle onto the bank write port (RegW/Dir/Din). Pending entries are
// snooped by the two bank read addresses so readers see the newest value.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        writeback request handshake (in_ready = !full)
//   in_dir, in_data          destination register and value
//   wb_hold                  suspend draining while high
//   RegW, Dir, Din           bank write port (Dir/Din are 0 when RegW=0)
//   RA1, RA2                 bank read addresses being snooped
//   hit1/fwd1, hit2/fwd2     forwarding result, youngest matching entry
//   count, empty             occupancy
//
// Configuration macro: BR_WB_FWD_EN
//   defined   -> forwarding comparators present
//   undefined -> hit*/fwd* tied to 0, queue and drain unchanged

module br_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_dir,
    input  logic [DW-1:0]            in_data,
    input  logic                     wb_hold,
    output logic                     RegW,
    output logic [AW-1:0]            Dir,
    output logic [DW-1:0]            Din,
    input  logic [AW-1:0]            RA1,
    input  logic [AW-1:0]            RA2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_dir_q  [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic push;
    logic pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        // Full blocks the request even if the head pops this cycle.
        in_ready = !full;
        // Writes to register 0 complete the handshake but are dropped.
        push     = in_valid && in_ready && (in_dir != '0);
        RegW     = !empty && !wb_hold;
        pop      = RegW;
        Dir      = RegW ? ent_dir_q[rd_ptr_q]  : '0;
        Din      = RegW ? ent_data_q[rd_ptr_q] : '0;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_dir_q[wr_ptr_q]  <= in_dir;
            ent_data_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef BR_WB_FWD_EN
    // Walk from head (oldest) to tail so a later match overrides an
    // earlier one, leaving the youngest matching entry's data.
    always_comb begin
        logic [PW-1:0] idx;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((RA1 != '0) && (ent_dir_q[idx] == RA1)) begin
                    hit1 = 1'b1;
                    fwd1 = ent_data_q[idx];
                end
                if ((RA2 != '0) && (ent_dir_q[idx] == RA2)) begin
                    hit2 = 1'b1;
                    fwd2 = ent_data_q[idx];
                end
            end
        end
    end
`else
    logic unused_ra;
    assign unused_ra = ^{RA1, RA2};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

endmodule
